// File: rtl/uio_arb_pkg.sv
// Shared types and the round-robin helper for the uio pin arbiter.
package uio_arb_pkg;

  localparam int unsigned MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    TURN
  } state_t;

  // Index of the first set request after `last`, wrapping modulo nreq.
  function automatic logic [2:0] rr_next_idx(input logic [MAX_REQ-1:0] req,
                                             input logic [2:0]         last,
                                             input int unsigned        nreq);
    logic [2:0]  idx;
    logic        found;
    int unsigned j;
    idx   = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      j = (32'(last) + k) % nreq;
      if (k <= nreq && !found && req[j[2:0]]) begin
        idx   = j[2:0];
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/uio_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending request after the last owner.
module rr_pick
  import uio_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [NREQ-1:0]         winner,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    valid
);

  localparam int unsigned OW = $clog2(NREQ);

  logic [MAX_REQ-1:0] req_ext;
  logic [2:0]         next_idx;

  always_comb begin
    req_ext           = '0;
    req_ext[NREQ-1:0] = req;
    next_idx          = rr_next_idx(req_ext, 3'(last), NREQ);
  end

  assign valid  = |req;
  assign idx    = OW'(next_idx);
  assign winner = valid ? (NREQ'(1) << idx) : '0;

endmodule

// File: rtl/uio_port_arbiter.sv
// Round-robin owner arbitration for the shared uio pins, with a tri-state turnaround.
// Define UIO_ARB_TIMEOUT_EN to preempt an owner after HOLD_MAX cycles when others wait.
module uio_port_arbiter
  import uio_arb_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned TURN_CYC = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*8-1:0]       dout,
  input  logic [NREQ*8-1:0]       doe,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic [7:0]              uio_out,
  output logic [7:0]              uio_oe
);

  localparam int unsigned OW = $clog2(NREQ);
  localparam int unsigned TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  if (NREQ < 2 || NREQ > MAX_REQ || HOLD_MAX < 1 || TURN_CYC < 1) begin : g_bad_param
    $error("uio_port_arbiter: parameter out of range");
  end

  state_t            state, state_nx;
  logic [NREQ-1:0]   gnt_nx;
  logic [OW-1:0]     owner_nx;
  logic [TW-1:0]     turn_cnt, turn_cnt_nx;
  logic [NREQ-1:0]   pick_gnt;
  logic [OW-1:0]     pick_idx;
  logic              pick_valid;
  logic              timeout;
  logic              do_arb;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .last   (owner),
    .winner (pick_gnt),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

`ifdef UIO_ARB_TIMEOUT_EN
  localparam int unsigned HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  logic [HW-1:0] hold_cnt, hold_nx;
  // gnt is the owner's one-hot while in OWN, so this masks out the owner itself.
  assign timeout = (hold_cnt == HW'(HOLD_MAX - 1)) && |(req & ~gnt);
`else
  assign timeout = 1'b0;
`endif

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_nx    = state;
    gnt_nx      = gnt;
    owner_nx    = owner;
    turn_cnt_nx = turn_cnt;
    do_arb      = 1'b0;
`ifdef UIO_ARB_TIMEOUT_EN
    hold_nx     = hold_cnt;
`endif
    case (state)
      IDLE: do_arb = 1'b1;
      OWN: begin
        if (!req[owner] || !ena || timeout) begin
          state_nx    = TURN;
          gnt_nx      = '0;
          turn_cnt_nx = '0;
        end
`ifdef UIO_ARB_TIMEOUT_EN
        else if (hold_cnt != HW'(HOLD_MAX - 1)) begin
          hold_nx = hold_cnt + 1'b1;
        end
`endif
      end
      TURN: begin
        if (turn_cnt == TW'(TURN_CYC - 1)) do_arb = 1'b1;
        else turn_cnt_nx = turn_cnt + 1'b1;
      end
      default: state_nx = IDLE;
    endcase

    // The last TURN cycle arbitrates directly, so no IDLE cycle is spent between owners.
    if (do_arb) begin
      if (ena && pick_valid) begin
        state_nx = OWN;
        gnt_nx   = pick_gnt;
        owner_nx = pick_idx;
`ifdef UIO_ARB_TIMEOUT_EN
        hold_nx  = '0;
`endif
      end else begin
        state_nx = IDLE;
      end
    end
  end

  // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= OW'(NREQ - 1);
      turn_cnt <= '0;
`ifdef UIO_ARB_TIMEOUT_EN
      hold_cnt <= '0;
`endif
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      owner    <= owner_nx;
      turn_cnt <= turn_cnt_nx;
`ifdef UIO_ARB_TIMEOUT_EN
      hold_cnt <= hold_nx;
`endif
    end
  end

  assign busy = (state != IDLE);

  // ena gates the pins combinationally so they release in the same cycle ena falls.
  always_comb begin
    uio_out = 8'h00;
    uio_oe  = 8'h00;
    if (state == OWN && ena) begin
      for (int i = 0; i < NREQ; i++) begin
        if (owner == OW'(i)) begin
          uio_out = dout[i*8 +: 8];
          uio_oe  = doe[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_uio_port_arbiter.sv
// Directed self-checking bench for uio_port_arbiter (NREQ=4, HOLD_MAX=4, TURN_CYC=1).
module tb_uio_port_arbiter;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned HOLD_MAX = 4;
  localparam int unsigned TURN_CYC = 1;

  logic              clk;
  logic              rst_n;
  logic              ena;
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] dout;
  logic [NREQ*8-1:0] doe;
  logic [NREQ-1:0]   gnt;
  logic [1:0]        owner;
  logic              busy;
  logic [7:0]        uio_out;
  logic [7:0]        uio_oe;

  uio_port_arbiter #(
    .NREQ     (NREQ),
    .HOLD_MAX (HOLD_MAX),
    .TURN_CYC (TURN_CYC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .req     (req),
    .dout    (dout),
    .doe     (doe),
    .gnt     (gnt),
    .owner   (owner),
    .busy    (busy),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; all sampling happens there.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drop all requests and walk through TURN back to IDLE.
  task automatic drain;
    req = '0;
    tick();
    tick();
  endtask

  logic [3:0] exp_to [11];

  initial begin
`ifdef UIO_ARB_TIMEOUT_EN
    exp_to = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
               4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
`else
    exp_to = '{default: 4'b0001};
`endif
    rst_n = 1'b0;
    ena   = 1'b1;
    req   = '0;
    dout  = '0;
    doe   = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_gnt",   32'(gnt),     32'h0);
    check("rst_owner", 32'(owner),   32'h3);
    check("rst_busy",  32'(busy),    32'h0);
    check("rst_oe",    32'(uio_oe),  32'h00);
    check("rst_out",   32'(uio_out), 32'h00);

    // Single owner grant, release and one turnaround cycle.
    dout[15:8] = 8'hA5;
    doe[15:8]  = 8'hF0;
    req = 4'b0010;
    tick();
    check("single_gnt",   32'(gnt),     32'h2);
    check("single_out",   32'(uio_out), 32'hA5);
    check("single_oe",    32'(uio_oe),  32'hF0);
    check("single_owner", 32'(owner),   32'h1);
    check("single_busy",  32'(busy),    32'h1);
    req = 4'b0000;
    tick();
    check("rel_gnt",  32'(gnt),    32'h0);
    check("rel_oe",   32'(uio_oe), 32'h00);
    check("rel_busy", 32'(busy),   32'h1);
    tick();
    check("idle_busy",  32'(busy),   32'h0);
    check("idle_owner", 32'(owner),  32'h1);
    check("idle_oe",    32'(uio_oe), 32'h00);

    // Asynchronous reset while owning.
    doe[15:8] = 8'hFF;
    req = 4'b0010;
    tick();
    check("pre_rst_oe", 32'(uio_oe), 32'hFF);
    rst_n = 1'b0;
    #1;
    check("arst_gnt",  32'(gnt),     32'h0);
    check("arst_oe",   32'(uio_oe),  32'h00);
    check("arst_out",  32'(uio_out), 32'h00);
    check("arst_busy", 32'(busy),    32'h0);
    req = '0;
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_busy",  32'(busy),  32'h0);
    check("post_rst_owner", 32'(owner), 32'h3);

    // Simultaneous requests after reset: req0 wins, then req2 after one TURN.
    req = 4'b0101;
    tick();
    check("sim_first", 32'(gnt), 32'h1);
    req = 4'b0100;
    tick();
    check("sim_turn_gnt", 32'(gnt),    32'h0);
    check("sim_turn_oe",  32'(uio_oe), 32'h00);
    tick();
    check("sim_second", 32'(gnt),   32'h4);
    check("sim_owner",  32'(owner), 32'h2);
    drain();

    // Timeout / hold behaviour with req0 and req3 both held from reset.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    req = 4'b1001;
    tick();
    for (int c = 0; c < 11; c++) begin
      check($sformatf("hold_c%0d", c + 1), 32'(gnt), 32'(exp_to[c]));
      tick();
    end
    drain();

    // Lone owner never gets a turnaround inserted.
    req = 4'b0010;
    tick();
    for (int c = 0; c < 20; c++) begin
      check($sformatf("lone_c%0d", c + 1), 32'(gnt), 32'h2);
      tick();
    end
    drain();

    // ena drop while req2 owns.
    dout[23:16] = 8'h5A;
    doe[23:16]  = 8'h3C;
    req = 4'b0100;
    tick();
    check("ena_gnt", 32'(gnt),     32'h4);
    check("ena_oe",  32'(uio_oe),  32'h3C);
    check("ena_out", 32'(uio_out), 32'h5A);
    ena = 1'b0;
    #1;
    check("ena_off_oe",  32'(uio_oe),  32'h00);
    check("ena_off_out", 32'(uio_out), 32'h00);
    tick();
    check("ena_off_gnt",  32'(gnt),  32'h0);
    check("ena_off_busy", 32'(busy), 32'h1);
    ena = 1'b1;
    tick();
    check("ena_back_gnt", 32'(gnt),    32'h4);
    check("ena_back_oe",  32'(uio_oe), 32'h3C);
    drain();

    // No grant while ena is low, even from IDLE.
    ena = 1'b0;
    req = 4'b0001;
    tick();
    check("noena_gnt",  32'(gnt),  32'h0);
    check("noena_busy", 32'(busy), 32'h0);
    tick();
    check("noena_gnt2", 32'(gnt), 32'h0);
    ena = 1'b1;
    tick();
    check("ena_grant", 32'(gnt), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uio_port_arbiter.md
# uio_port_arbiter

Shares the 8 bidirectional `uio` pins of the `tt_um_uabc_test2024_AGV` top between up to NREQ internal requesters. Each requester asks for the pins; the arbiter grants one owner at a time in round-robin order and muxes that owner's data and output-enable onto `uio_out`/`uio_oe`. Between owners it inserts a turnaround gap with all pins tri-stated. It sits directly under the top module, between the user logic and the `uio_*` ports.

## Interface
- NREQ, 4: number of requesters, 2..8.
- HOLD_MAX, 8: maximum grant length in cycles when another requester is waiting; >=1.
- TURN_CYC, 1: turnaround cycles with `uio_oe`=0 between owners; >=1.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  design enable; low forces release.
- req  in  NREQ  per-requester request, level.
- dout  in  NREQ*8  requester i drives bits [8i+7:8i] toward `uio_out`.
- doe  in  NREQ*8  requester i output-enable mask, same packing.
- gnt  out  NREQ  one-hot grant, registered.
- owner  out  $clog2(NREQ)  index of current/last owner, registered.
- busy  out  1  high in OWN or TURN.
- uio_out  out  8  muxed owner data.
- uio_oe  out  8  muxed owner enable (1 = drive).

## Operation
- States: IDLE, OWN, TURN. Reset values: IDLE, gnt=0, owner=NREQ-1, busy=0, hold counter=0, uio_out=0x00, uio_oe=0x00.
- Arbitration (IDLE, or last TURN cycle): if ena and |req, pick the first set req scanning from owner+1 upward, modulo NREQ. Go to OWN, load gnt/owner, clear hold counter. Otherwise stay in or go to IDLE.
- OWN: hold counter increments each cycle and saturates at HOLD_MAX-1.
  - Exit to TURN when req[owner]=0.
  - Exit to TURN on timeout (see Configuration).
  - Exit to TURN when ena=0.
  - On any exit, gnt clears at the same edge.
- TURN: lasts exactly TURN_CYC cycles with gnt=0 and uio_oe=0. At the edge ending the last cycle, arbitrate as in IDLE. There is no extra IDLE cycle.
- Mux: uio_out = dout[owner] and uio_oe = doe[owner] only when state=OWN and ena=1; otherwise both are 0x00.
- ena=0 tri-states the pins combinationally in the same cycle. The state reaches TURN, then IDLE. No grant is issued while ena=0.
- A preempted owner that keeps req high re-enters rotation normally. It is served after all other pending requesters.
- rst_n assertion mid-OWN: gnt, uio_oe and uio_out go to 0 immediately (asynchronously); the state is IDLE.

## Timing
- Request to grant: req sampled high at edge k in IDLE gives gnt valid after edge k, and pins driven in the same cycle.
- Release: req[owner] low sampled at edge k gives gnt=0 after edge k, then TURN_CYC tri-state cycles.
- Back-to-back handover: the next owner's gnt rises TURN_CYC cycles after the previous gnt falls.
- `owner` is stable through TURN and IDLE and holds the last owner.

## Configuration
- `UIO_ARB_TIMEOUT_EN` defined: preemption is enabled. In OWN, when the hold counter = HOLD_MAX-1 and any other req is high, exit to TURN. If no other requester is pending, the owner keeps the pins and the counter stays saturated.
- `UIO_ARB_TIMEOUT_EN` undefined: there is no hold counter and HOLD_MAX is ignored. The owner keeps the pins until its req falls or ena=0.

## Structure
- Package `uio_arb_pkg`:
  - state enum (IDLE/OWN/TURN);
  - function for round-robin next-index.
- Sub-module `rr_pick`: combinational round-robin picker (req, last owner -> one-hot winner plus valid flag).
- Counters and the pin mux stay in the top arbiter.

## Test plan
(All scenarios use NREQ=4, HOLD_MAX=4, TURN_CYC=1.)
- Reset mid-grant: req1 owning with doe1=0xFF, pull rst_n low -> immediately gnt=0000, uio_oe=0x00, uio_out=0x00; after release, busy=0 and owner=3.
- Single owner: req1=1, dout1=0xA5, doe1=0xF0 -> after next edge gnt=0010, uio_out=0xA5, uio_oe=0xF0. Drop req1 -> gnt=0000 after next edge, then one cycle of uio_oe=0x00, then IDLE.
- Simultaneous: req0 and req2 rise together after reset -> req0 granted first. Drop req0 -> 1 TURN cycle, then gnt=0100.
- Timeout (EN defined): req0 and req3 held high -> req0 owns 4 cycles, TURN 1 cycle, req3 owns 4 cycles, TURN 1 cycle, then req0. EN undefined: req0 owns indefinitely.
- Lone owner, EN defined: only req1 held for 20 cycles -> gnt=0010 throughout, no TURN inserted.
- ena drop: ena=0 while req2 owns -> uio_oe=0x00 in the same cycle and gnt=0000 after the edge. ena=1 again with req2 high -> gnt=0100 after TURN completes.
